// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: keeps up to MAX_OUTSTANDING word fetches in flight on the
// req/gnt/rvalid port, queues responses with their addresses in a DEPTH-entry FIFO, and on a
// branch flushes the FIFO and drops every response still in flight.
module prefetch_buffer #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,

    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    output logic        busy_o,

    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] BootAddrAligned = {BOOT_ADDR[31:2], 2'b00};

    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   resp_addr_q, resp_addr_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic          stale_q, stale_d;
    logic [31:0]   stale_addr_q, stale_addr_d;
    logic          held_q, held_d;

    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];

    logic          credit_ok;
    logic          grant;
    logic          rsp;
    logic          drop;
    logic          push;
    logic          pop;
    logic [31:0]   branch_target;
    logic          unused_branch_lsb;

    assign branch_target     = {branch_addr_i[31:2], 2'b00};
    assign unused_branch_lsb = ^branch_addr_i[1:0];

    // Issue side: request is a function of registered state and req_i only.
    always_comb begin
        credit_ok = (32'(outstanding_q) < MAX_OUTSTANDING) &&
                    ((32'(fifo_cnt_q) + 32'(outstanding_q)) < DEPTH);
        instr_req_o   = stale_q | held_q | (req_i & credit_ok);
        instr_addr_o  = stale_q ? stale_addr_q : fetch_addr_q;
        fetch_valid_o = (fifo_cnt_q != '0) & ~branch_i;
        fetch_rdata_o = fifo_data_q[rd_ptr_q];
        fetch_addr_o  = fifo_addr_q[rd_ptr_q];
        busy_o        = (outstanding_q != '0);
    end

    // Next-state: grant/response bookkeeping, FIFO pointers, branch flush.
    always_comb begin
        grant = instr_req_o & instr_gnt_i;
        // A response with nothing outstanding belongs to a request from before reset.
        rsp   = instr_rvalid_i & (outstanding_q != '0);
        drop  = rsp & (discard_q != '0);
        push  = rsp & ~drop & ~branch_i;
        pop   = fetch_valid_o & fetch_ready_i;

        outstanding_d = outstanding_q + OW'(grant) - OW'(rsp);
        held_d        = instr_req_o & ~instr_gnt_i;
        fetch_addr_d  = fetch_addr_q;
        resp_addr_d   = resp_addr_q;
        discard_d     = discard_q;
        stale_d       = stale_q;
        stale_addr_d  = stale_addr_q;
        fifo_cnt_d    = fifo_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (branch_i) begin
            // Everything still in flight after this edge is from the old path.
            discard_d    = outstanding_d;
            fetch_addr_d = branch_target;
            resp_addr_d  = branch_target;
            // An ungranted request cannot be withdrawn; remember it so its reply gets dropped.
            stale_d      = instr_req_o & ~instr_gnt_i;
            stale_addr_d = instr_addr_o;
            fifo_cnt_d   = '0;
            rd_ptr_d     = wr_ptr_q;
        end else begin
            discard_d = discard_q + OW'(grant & stale_q) - OW'(drop);
            if (grant) begin
                stale_d = 1'b0;
                if (!stale_q) begin
                    fetch_addr_d = fetch_addr_q + 32'd4;
                end
            end
            if (push) begin
                resp_addr_d = resp_addr_q + 32'd4;
                wr_ptr_d    = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q  <= BootAddrAligned;
            resp_addr_q   <= BootAddrAligned;
            outstanding_q <= '0;
            discard_q     <= '0;
            stale_q       <= 1'b0;
            stale_addr_q  <= '0;
            held_q        <= 1'b0;
            fifo_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            resp_addr_q   <= resp_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            stale_q       <= stale_d;
            stale_addr_q  <= stale_addr_d;
            held_q        <= held_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_addr_q <= '{default: '0};
            fifo_data_q <= '{default: '0};
        end else if (push) begin
            fifo_addr_q[wr_ptr_q] <= resp_addr_q;
            fifo_data_q[wr_ptr_q] <= instr_rdata_i;
        end
    end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Parametrised instruction prefetch unit between the IF stage and the instruction memory port. It issues word fetches on the req/gnt/rvalid instruction interface, keeping up to MAX_OUTSTANDING requests in flight. Responses are buffered in a DEPTH-entry FIFO with their addresses. On a branch redirect it flushes the FIFO and discards stale in-flight responses, which the single-request fetch path cannot do.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered requests; 1..DEPTH.
- BOOT_ADDR, 32'h0000_0080: first fetch address after reset; bits [1:0] ignored.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch enable from IF stage.
- branch_i  in  1  redirect strobe, single cycle.
- branch_addr_i  in  32  redirect target; bits [1:0] forced to 0.
- fetch_valid_o  out  1  FIFO head valid.
- fetch_ready_i  in  1  IF stage consumes head.
- fetch_rdata_o  out  32  instruction word at head.
- fetch_addr_o  out  32  address of head word.
- busy_o  out  1  at least one request outstanding.
- instr_req_o  out  1  memory request.
- instr_gnt_i  in  1  memory grant.
- instr_addr_o  out  32  request address, word-aligned.
- instr_rvalid_i  in  1  response valid.
- instr_rdata_i  in  32  response data.

## Operation
- State:
  - fetch_addr_q: next address to issue.
  - resp_addr_q: address of the next non-discarded response.
  - outstanding_q: width $clog2(MAX_OUTSTANDING+1).
  - discard_q: outstanding responses to drop; always ≤ outstanding_q.
  - FIFO of {addr, data} with count.
  - stale_q/stale_addr_q: ungranted request held across a branch.
- Issue:
  - instr_req_o = stale_q | held_q | (req_i & outstanding_q < MAX_OUTSTANDING & fifo_cnt + outstanding_q < DEPTH).
  - Once asserted, instr_req_o stays high with a stable instr_addr_o until instr_gnt_i, regardless of req_i, branch_i or credits. held_q tracks this.
  - instr_addr_o = stale_q ? stale_addr_q : fetch_addr_q.
- Grant (instr_req_o & instr_gnt_i): outstanding_q+1.
  - Non-stale grant: fetch_addr_q += 4, wrapping mod 2^32.
  - Stale grant: also discard_q+1; stale_q clears and fetch_addr_q is unchanged.
- Response (instr_rvalid_i): outstanding_q−1.
  - If discard_q>0: discard_q−1 and data is dropped.
  - Otherwise: push {resp_addr_q, instr_rdata_i}; resp_addr_q += 4.
  - instr_rvalid_i with outstanding_q==0 is ignored; no counter underflow.
- Credit rule guarantees a push never finds the FIFO full. Grant and response in the same cycle leave outstanding_q unchanged.
- Pop on fetch_valid_o & fetch_ready_i. Simultaneous push and pop leave the count unchanged; a push into an empty FIFO is visible the next cycle.
- Branch, which overrides everything else in that cycle:
  - FIFO count → 0; pop suppressed; a same-cycle rvalid is dropped.
  - discard_q ← outstanding_q + grant − rvalid, i.e. all in-flight requests after this cycle.
  - fetch_addr_q ← resp_addr_q ← {branch_addr_i[31:2], 2'b00}.
  - If instr_req_o is high and not granted this cycle: stale_q ← 1 and stale_addr_q ← current instr_addr_o.
  - A branch while stale_q is already set keeps stale_q and updates fetch_addr_q.

## Timing
- Reset values:
  - instr_req_o=0, instr_addr_o=BOOT_ADDR & ~3.
  - fetch_valid_o=0, fetch_rdata_o=0, fetch_addr_o=0, busy_o=0.
  - All counters 0; stale_q=0.
- instr_req_o depends only on registered state and req_i. There is no combinational path from instr_gnt_i, instr_rvalid_i or fetch_ready_i to instr_req_o.
- fetch_valid_o = fifo_cnt≠0 & ~branch_i.
- Latency: request granted in cycle N, rvalid in N+1, fetch_valid_o in N+2.
- Freed credit (pop or grant/response change) is usable in the next cycle.
- busy_o = outstanding_q≠0, registered.
- Reset mid-operation clears all state. Responses arriving after reset for pre-reset requests hit outstanding_q==0 and are ignored.

## Test plan
- Reset, req_i=1, gnt same cycle, rvalid one cycle later, ready=1 -> requests at 0x80, 0x84, 0x88…; first fetch_valid_o two cycles after first grant with fetch_addr_o=0x80; one instruction per cycle thereafter.
- DEPTH=4, fetch_ready_i=0, immediate gnt/rvalid -> exactly 4 grants then instr_req_o=0; one pop -> exactly one new request in the following cycle.
- MAX_OUTSTANDING=2, rvalid latency 5 cycles -> outstanding never exceeds 2; busy_o high throughout; output addresses strictly sequential.
- Two requests outstanding, branch_i with branch_addr_i=0x203 -> FIFO empties; the 2 late responses are dropped; next fetch_addr_o=0x200 and next instr_addr_o=0x200.
- instr_req_o high at 0x90 with gnt held low 3 cycles, branch to 0x200 in the first of those cycles -> instr_addr_o stays 0x90 until granted; next request is 0x200; the 0x90 response never appears on the fetch outputs.
- rst_ni pulsed low with 2 outstanding and 3 FIFO entries -> all outputs return to reset values immediately; 2 subsequent rvalids are ignored; fetch restarts at 0x80.
